// File: rtl/manual_driving_mode.sv
// Manual-drive controller: decodes pedals, gear levers and turn switches
// into a 4-state engine FSM and produces registered chassis command (rec),
// status/LED (answer) and engine state (state1) outputs.
module manual_driving_mode #(
   parameter int unsigned BLINK_DIV = 50_000_000  // cycles per lamp toggle, >= 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       throttle,
   input  logic       clutch,
   input  logic       brake,
   input  logic       turn_left_signal,
   input  logic       turn_right_signal,
   input  logic       move_forward_signal,
   input  logic       move_backward_signal,
   output logic [7:0] rec,
   output logic [7:0] answer,
   output logic [1:0] state1
);

   // Engine states, encoding is visible on state1.
   localparam logic [1:0] NOT_STARTED = 2'b00;
   localparam logic [1:0] STARTING    = 2'b01;
   localparam logic [1:0] MOVING      = 2'b10;
   localparam logic [1:0] POWER_OFF   = 2'b11;

   // Decoded gear lever position.
   localparam logic [1:0] GEAR_N = 2'b00;
   localparam logic [1:0] GEAR_F = 2'b01;
   localparam logic [1:0] GEAR_R = 2'b10;

   localparam int unsigned      CNT_W    = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [1:0]       gear;
   logic [1:0]       prev_gear_q;
   logic [CNT_W-1:0] blink_cnt_q;
   logic [CNT_W-1:0] blink_cnt_d;
   logic             lamp_q;
   logic             lamp_d;
   logic             turn_left_d;
   logic             turn_right_d;
   logic [7:0]       rec_d;
   logic [7:0]       answer_d;

   assign state1 = state_q;

   // Gear decode: both or neither lever means neutral.
   always_comb begin
      if (move_forward_signal && !move_backward_signal) begin
         gear = GEAR_F;
      end else if (move_backward_signal && !move_forward_signal) begin
         gear = GEAR_R;
      end else begin
         gear = GEAR_N;
      end
   end

   // Engine next-state logic; conditions are tested in priority order.
   always_comb begin
      // NOTE: default assignment first so every path drives state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         NOT_STARTED: begin
            if (throttle && !clutch && !brake) begin
               state_d = POWER_OFF;              // throttle without clutch stalls
            end else if (throttle && clutch && !brake) begin
               state_d = STARTING;
            end
         end
         STARTING: begin
            if (brake) begin
               state_d = NOT_STARTED;
            end else if (throttle && !clutch) begin
               state_d = MOVING;
            end
         end
         MOVING: begin
            if (brake) begin
               state_d = NOT_STARTED;
            end else if ((gear != prev_gear_q) && !clutch) begin
               state_d = POWER_OFF;              // gear change without clutch stalls
            end else if (!throttle || clutch) begin
               state_d = STARTING;
            end
         end
         default: begin
            state_d = POWER_OFF;                 // absorbing until reset
         end
      endcase
   end

   // Turn request and lamp blinker; a new direction restarts the blink phase.
   always_comb begin
      turn_left_d  = turn_left_signal && !turn_right_signal && (state_d != POWER_OFF);
      turn_right_d = turn_right_signal && !turn_left_signal && (state_d != POWER_OFF);
      blink_cnt_d  = blink_cnt_q;
      lamp_d       = lamp_q;
      if (!turn_left_d && !turn_right_d) begin
         blink_cnt_d = '0;
         lamp_d      = 1'b0;
      end else if ({turn_right_d, turn_left_d} != rec[3:2]) begin
         blink_cnt_d = '0;
         lamp_d      = 1'b1;                     // lamp is on in the first active cycle
      end else if (blink_cnt_q == CNT_LAST) begin
         blink_cnt_d = '0;
         lamp_d      = !lamp_q;
      end else begin
         blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
   end

   // Output bytes computed from the next state so they line up with state1.
   always_comb begin
      rec_d      = 8'h00;
      rec_d[0]   = (state_d == MOVING) && (gear == GEAR_F);
      rec_d[1]   = (state_d == MOVING) && (gear == GEAR_R);
      rec_d[2]   = turn_left_d;
      rec_d[3]   = turn_right_d;

      answer_d    = 8'h00;
      answer_d[0] = 1'b1;
      answer_d[1] = (state_d == MOVING);
      answer_d[2] = (gear == GEAR_R);
      answer_d[3] = lamp_d && turn_left_d;
      answer_d[4] = lamp_d && turn_right_d;
      answer_d[5] = brake;
      answer_d[6] = clutch;
      answer_d[7] = throttle;
      if (state_d == POWER_OFF) begin
         answer_d = 8'h00;                       // dark panel once the engine has stalled
      end
   end

   // State, gear history, blinker and output registers.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it is only honoured on a clock edge.
      if (!rst) begin
         state_q     <= NOT_STARTED;
         prev_gear_q <= gear;
         blink_cnt_q <= '0;
         lamp_q      <= 1'b0;
         rec         <= 8'h00;
         answer      <= 8'h01;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         prev_gear_q <= gear;
         blink_cnt_q <= blink_cnt_d;
         lamp_q      <= lamp_d;
         rec         <= rec_d;
         answer      <= answer_d;
      end
   end

endmodule

// File: tb/tb_manual_driving_mode.sv
// Self-checking bench for manual_driving_mode: directed scenarios followed
// by randomized driving, all compared against a behavioural model.
module tb_manual_driving_mode;

   localparam int unsigned BLINK = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       throttle, clutch, brake;
   logic       turn_left_signal, turn_right_signal;
   logic       move_forward_signal, move_backward_signal;
   logic [7:0] rec, answer;
   logic [1:0] state1;

   int n_vec = 0;
   int n_err = 0;

   // Model state: engine phase as a name, turn direction and its age in cycles.
   typedef enum int {M_IDLE = 0, M_START = 1, M_MOVE = 2, M_DEAD = 3} phase_t;
   phase_t     m_phase;
   int         m_prev_gear;   // 0 neutral, 1 forward, 2 reverse
   int         m_dir;         // 0 none, 1 left, 2 right
   int         m_age;
   logic [7:0] m_rec, m_ans;

   manual_driving_mode #(.BLINK_DIV(BLINK)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .throttle             (throttle),
      .clutch               (clutch),
      .brake                (brake),
      .turn_left_signal     (turn_left_signal),
      .turn_right_signal    (turn_right_signal),
      .move_forward_signal  (move_forward_signal),
      .move_backward_signal (move_backward_signal),
      .rec                  (rec),
      .answer               (answer),
      .state1               (state1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h, expected %02h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model of one clock edge using the current inputs.
   task automatic model_step();
      int     g;
      phase_t nxt;
      logic   fwd, bwd, left, right, lamp;
      int     new_dir;
      g = (move_forward_signal && !move_backward_signal) ? 1 :
          (move_backward_signal && !move_forward_signal) ? 2 : 0;
      if (!rst) begin
         m_phase = M_IDLE; m_rec = 8'h00; m_ans = 8'h01;
         m_dir = 0; m_age = 0; m_prev_gear = g;
         return;
      end
      nxt = m_phase;
      case (m_phase)
         M_IDLE:  if (throttle && !clutch && !brake) nxt = M_DEAD;
                  else if (throttle && clutch && !brake) nxt = M_START;
         M_START: if (brake) nxt = M_IDLE;
                  else if (throttle && !clutch) nxt = M_MOVE;
         M_MOVE:  if (brake) nxt = M_IDLE;
                  else if (g != m_prev_gear && !clutch) nxt = M_DEAD;
                  else if (!throttle || clutch) nxt = M_START;
         default: nxt = M_DEAD;
      endcase
      fwd   = (nxt == M_MOVE) && (g == 1);
      bwd   = (nxt == M_MOVE) && (g == 2);
      left  = turn_left_signal && !turn_right_signal && (nxt != M_DEAD);
      right = turn_right_signal && !turn_left_signal && (nxt != M_DEAD);
      new_dir = left ? 1 : (right ? 2 : 0);
      if (new_dir == 0 || new_dir != m_dir) m_age = 0;
      else m_age++;
      lamp  = (new_dir != 0) && (((m_age / BLINK) % 2) == 0);
      m_rec = {4'b0000, right, left, bwd, fwd};
      if (nxt == M_DEAD) m_ans = 8'h00;
      else m_ans = {throttle, clutch, brake, lamp && right, lamp && left,
                    (g == 2) ? 1'b1 : 1'b0, (nxt == M_MOVE) ? 1'b1 : 1'b0, 1'b1};
      m_phase = nxt; m_prev_gear = g; m_dir = new_dir;
   endtask

   // Apply inputs, take one edge, compare DUT against the model.
   task automatic cyc(input logic r, input logic thr, input logic clu, input logic brk,
                      input logic tl, input logic tr, input logic fw, input logic bw);
      rst = r; throttle = thr; clutch = clu; brake = brk;
      turn_left_signal = tl; turn_right_signal = tr;
      move_forward_signal = fw; move_backward_signal = bw;
      @(posedge clk);
      model_step();
      #1;
      check("state1", {6'b0, state1}, {6'b0, 2'(int'(m_phase))});
      check("rec",    rec,    m_rec);
      check("answer", answer, m_ans);
   endtask

   logic [11:0] blink_pat;

   initial begin
      // Reset held with all inputs low, then all high.
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0, 0);
         check("rst0_state", {6'b0, state1}, 8'h00);
         check("rst0_ans", answer, 8'h01);
      end
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 1, 1, 1, 1, 1, 1);
         check("rst1_rec", rec, 8'h00);
         check("rst1_ans", answer, 8'h01);
      end

      // Start, drive forward, release throttle.
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      check("start_state", {6'b0, state1}, 8'h01);
      cyc(1, 1, 0, 0, 0, 0, 1, 0);
      check("move_state", {6'b0, state1}, 8'h02);
      check("move_rec", rec, 8'h01);
      cyc(1, 0, 0, 0, 0, 0, 1, 0);
      check("coast_state", {6'b0, state1}, 8'h01);
      check("coast_rec", rec, 8'h00);

      // Stall from NOT_STARTED, absorbing until reset.
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      check("stall_state", {6'b0, state1}, 8'h03);
      check("stall_ans", answer, 8'h00);
      for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 1, 0, 1, 0);
      check("dead_state", {6'b0, state1}, 8'h03);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("dead_rst", answer, 8'h01);

      // Gear change in MOVING without clutch stalls; with clutch it drops to STARTING.
      cyc(1, 1, 1, 0, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 1);
      check("gear_stall", {6'b0, state1}, 8'h03);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(1, 1, 1, 0, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 1, 0);
      cyc(1, 1, 1, 0, 0, 0, 0, 1);
      check("gear_clutch", {6'b0, state1}, 8'h01);
      check("gear_rev", {7'b0, answer[2]}, 8'h01);

      // Brake in MOVING and in STARTING.
      cyc(1, 1, 0, 0, 0, 0, 0, 1);
      cyc(1, 1, 0, 1, 0, 0, 0, 1);
      check("brake_move", {6'b0, state1}, 8'h00);
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 0, 0, 0, 0);
      check("brake_start", {6'b0, state1}, 8'h00);

      // Left blinker in STARTING, then both switches.
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      blink_pat = 12'b1111_0000_1111;
      for (int i = 0; i < 12; i++) begin
         cyc(1, 1, 1, 0, 1, 0, 0, 0);
         check("blink_rec", rec, 8'h04);
         check("blink_lamp", {7'b0, answer[3]}, {7'b0, blink_pat[11 - i]});
      end
      cyc(1, 1, 1, 0, 1, 1, 0, 0);
      check("both_turn", rec & 8'h0C, 8'h00);
      check("both_lamp", answer & 8'h18, 8'h00);

      // Randomized driving.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(99) >= 2),
             ($urandom_range(99) < 75), ($urandom_range(99) < 35),
             ($urandom_range(99) < 8),
             ($urandom_range(99) < 40), ($urandom_range(99) < 25),
             ($urandom_range(99) < 60), ($urandom_range(99) < 20));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
